// File: rtl/fp_div_pkg.sv
// Shared FP32 field constants, special-operand test and divider tag type.
package fp_div_pkg;

   localparam int unsigned FP_W      = 32;
   localparam int unsigned SIGN_BIT  = 31;
   localparam int unsigned EXP_MSB   = 30;
   localparam int unsigned EXP_LSB   = 23;
   localparam int unsigned EXP_W     = 8;
   localparam int unsigned MAN_MSB   = 22;
   localparam int unsigned EXP_BIAS  = 127;
   localparam int unsigned EXP_MAX   = 255;

   // Wide enough for the largest supported requester count (8).
   localparam int unsigned TAG_IDX_W = 3;

   // One in-flight divider operation.
   typedef struct packed {
      logic                 valid;
      logic [TAG_IDX_W-1:0] idx;
      logic                 exc;
   } tag_t;

   // Zero/denormal or inf/NaN exponent: divider result is not trustworthy.
   function automatic logic is_special(input logic [FP_W-1:0] x);
      logic [EXP_W-1:0] e;
      e = x[EXP_MSB:EXP_LSB];
      return (e == '0) || (e == EXP_W'(EXP_MAX));
   endfunction

endpackage

// File: rtl/fp_div_sched_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, with wrap.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt_c,
   output logic [IDX_W-1:0]   gnt_idx_c,
   output logic               gnt_any_c
);

   // Upward search from ptr; the first hit wins, so the grant is one-hot or zero.
   always_comb begin
      int unsigned j;
      gnt_c     = '0;
      gnt_idx_c = '0;
      gnt_any_c = 1'b0;
      j         = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         j = (32'(ptr) + k) % NUM_REQ;
         if (!gnt_any_c && req[j]) begin
            gnt_c[j]  = 1'b1;
            gnt_idx_c = IDX_W'(j);
            gnt_any_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_div_sched.sv
// Shares one pipelined FP32 divider between NUM_REQ valid/ready requesters.
module fp_div_sched
   import fp_div_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DIV_LAT = 2,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [FP_W*NUM_REQ-1:0] req_a,
   input  logic [FP_W*NUM_REQ-1:0] req_b,
   output logic [FP_W-1:0]         div_a,
   output logic [FP_W-1:0]         div_b,
   input  logic [FP_W-1:0]         div_c,
   output logic [NUM_REQ-1:0]      rsp_valid,
   input  logic [NUM_REQ-1:0]      rsp_ready,
   output logic [FP_W*NUM_REQ-1:0] rsp_data,
   output logic [NUM_REQ-1:0]      rsp_exc
);

   logic [NUM_REQ-1:0]      busy_q, busy_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   tag_t                    tag_q [DIV_LAT];
   tag_t                    tag_d [DIV_LAT];
   logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
   logic [FP_W*NUM_REQ-1:0] rsp_data_q, rsp_data_d;
   logic [NUM_REQ-1:0]      rsp_exc_q, rsp_exc_d;

   logic [NUM_REQ-1:0]      drain_c;
   logic [NUM_REQ-1:0]      elig_c;
   logic [NUM_REQ-1:0]      gnt_c;
   logic [IDX_W-1:0]        gnt_idx_c;
   logic                    gnt_any_c;
   logic [FP_W-1:0]         op_a_c;
   logic [FP_W-1:0]         op_b_c;
   logic                    op_exc_c;
   tag_t                    wb_c;
   logic [IDX_W-1:0]        wb_idx_c;

   // A result consumed this cycle frees its requester for an immediate reissue.
   assign drain_c = rsp_valid_q & rsp_ready;
   assign elig_c  = req_valid & (~busy_q | drain_c);

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req       (elig_c),
      .ptr       (rr_ptr_q),
      .gnt_c     (gnt_c),
      .gnt_idx_c (gnt_idx_c),
      .gnt_any_c (gnt_any_c)
   );

   // Operand mux for the granted requester; idle bus is zero.
   always_comb begin
      op_a_c   = '0;
      op_b_c   = '0;
      op_exc_c = 1'b0;
      if (gnt_any_c) begin
         op_a_c   = req_a[FP_W*32'(gnt_idx_c) +: FP_W];
         op_b_c   = req_b[FP_W*32'(gnt_idx_c) +: FP_W];
         op_exc_c = is_special(op_a_c) | is_special(op_b_c);
      end
   end

   assign req_ready = gnt_c;
   assign div_a     = op_a_c;
   assign div_b     = op_b_c;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_exc   = rsp_exc_q;

   assign wb_c     = tag_q[DIV_LAT-1];
   assign wb_idx_c = IDX_W'(wb_c.idx);

   // Next state: credits, pointer, tag shift and result-buffer writeback.
   always_comb begin
      busy_d      = (busy_q & ~drain_c) | gnt_c;
      rr_ptr_d    = rr_ptr_q;
      rsp_valid_d = rsp_valid_q & ~drain_c;
      rsp_data_d  = rsp_data_q;
      rsp_exc_d   = rsp_exc_q;

      if (gnt_any_c) begin
         rr_ptr_d = (32'(gnt_idx_c) == NUM_REQ - 1) ? '0 : IDX_W'(32'(gnt_idx_c) + 1);
      end

      tag_d[0].valid = gnt_any_c;
      tag_d[0].idx   = TAG_IDX_W'(gnt_idx_c);
      tag_d[0].exc   = op_exc_c;
      for (int unsigned k = 1; k < DIV_LAT; k++) begin
         tag_d[k] = tag_q[k-1];
      end

      if (wb_c.valid) begin
         rsp_valid_d[wb_idx_c]                   = 1'b1;
         rsp_data_d[FP_W*32'(wb_idx_c) +: FP_W] = div_c;
         rsp_exc_d[wb_idx_c]                     = wb_c.exc;
      end
   end

   // State registers; reset discards every in-flight tag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= '0;
         rr_ptr_q    <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_exc_q   <= '0;
         for (int unsigned k = 0; k < DIV_LAT; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         busy_q      <= busy_d;
         rr_ptr_q    <= rr_ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_exc_q   <= rsp_exc_d;
         for (int unsigned k = 0; k < DIV_LAT; k++) begin
            tag_q[k] <= tag_d[k];
         end
      end
   end

   // The credit rule guarantees a writeback never lands on an unconsumed result.
   a_no_overwrite: assert property (@(posedge clk) disable iff (!rst_n)
      wb_c.valid |-> !(rsp_valid_q[wb_idx_c] && !rsp_ready[wb_idx_c]));

   // Never more than one issue per cycle.
   a_onehot_grant: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(gnt_c));

endmodule

// File: tb/tb_fp_div_sched.sv
// Bench for fp_div_sched with a behavioural two-stage divider and per-requester scoreboard.
module tb_fp_div_sched;
   import fp_div_pkg::*;

   localparam int unsigned NR = 4;

   logic            clk;
   logic            rst_n;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [32*NR-1:0] req_a;
   logic [32*NR-1:0] req_b;
   logic [31:0]     div_a;
   logic [31:0]     div_b;
   logic [31:0]     div_c;
   logic [NR-1:0]   rsp_valid;
   logic [NR-1:0]   rsp_ready;
   logic [32*NR-1:0] rsp_data;
   logic [NR-1:0]   rsp_exc;

   int tests;
   int fails;

   logic [32:0] sbq [NR][$];
   logic [32:0] exp_in [NR];
   int          gnt_log [$];

   logic [31:0] da_q, db_q, dc_q;

   fp_div_sched #(.NUM_REQ(NR), .DIV_LAT(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .div_a     (div_a),
      .div_b     (div_b),
      .div_c     (div_c),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_exc   (rsp_exc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference quotient via double precision; specials give a fixed NaN.
   function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] xa, xb, xq;
      real         ra, rb;
      int          e;
      if (is_special(a) || is_special(b)) return 32'h7FC00000;
      xa = {a[SIGN_BIT], 11'(a[EXP_MSB:EXP_LSB]) + 11'(1023 - EXP_BIAS), a[MAN_MSB:0], 29'd0};
      xb = {b[SIGN_BIT], 11'(b[EXP_MSB:EXP_LSB]) + 11'(1023 - EXP_BIAS), b[MAN_MSB:0], 29'd0};
      ra = $bitstoreal(xa);
      rb = $bitstoreal(xb);
      xq = $realtobits(ra / rb);
      e  = int'(xq[62:52]) - (1023 - int'(EXP_BIAS));
      if (e <= 0 || e >= int'(EXP_MAX)) return 32'h7FC00000;
      return {xq[63], 8'(e), xq[51:29]};
   endfunction

   // Divider model: registered operands, registered quotient.
   always @(posedge clk) begin
      da_q <= div_a;
      db_q <= div_b;
      dc_q <= fdiv(da_q, db_q);
   end
   assign div_c = dc_q;

   // Monitor: push on grant, pop and compare on response handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < int'(NR); i++) begin
            if (req_valid[i] && req_ready[i]) begin
               sbq[i].push_back(exp_in[i]);
               gnt_log.push_back(i);
               tests++;
               if (div_a !== req_a[32*i +: 32] || div_b !== req_b[32*i +: 32]) begin
                  fails++;
                  $display("FAIL operand_bus req%0d: div_a=%h div_b=%h, expected %h %h",
                           i, div_a, div_b, req_a[32*i +: 32], req_b[32*i +: 32]);
               end
            end
            if (rsp_valid[i] && rsp_ready[i]) begin
               tests++;
               if (sbq[i].size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_rsp req%0d: data=%h exc=%b with nothing outstanding",
                           i, rsp_data[32*i +: 32], rsp_exc[i]);
               end else begin
                  logic [32:0] e;
                  e = sbq[i].pop_front();
                  if ({rsp_exc[i], rsp_data[32*i +: 32]} !== e) begin
                     fails++;
                     $display("FAIL rsp_payload req%0d: exc=%b data=%h, expected exc=%b data=%h",
                              i, rsp_exc[i], rsp_data[32*i +: 32], e[32], e[31:0]);
                  end
               end
            end
         end
         tests++;
         if ((req_ready & ~req_valid) !== '0) begin
            fails++;
            $display("FAIL ready_without_valid: req_ready=%b req_valid=%b", req_ready, req_valid);
         end
         if (req_ready == '0) begin
            tests++;
            if (div_a !== 32'h0 || div_b !== 32'h0) begin
               fails++;
               $display("FAIL idle_bus: div_a=%h div_b=%h, expected 0 0", div_a, div_b);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, input logic e);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      exp_in[i]         = {e, d};
   endtask

   // Bounded wait for rsp_valid[i]; lat counts cycles advanced.
   task automatic wait_rsp(input int i, output int lat);
      lat = 0;
      while (!rsp_valid[i] && lat < 20) begin
         cyc(1);
         lat++;
      end
      tests++;
      if (!rsp_valid[i]) begin
         fails++;
         $display("FAIL rsp_timeout req%0d: no rsp_valid within %0d cycles, expected one", i, lat);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      tests++;
      if (rsp_valid !== '0 || rsp_exc !== '0 || rsp_data !== '0) begin
         fails++;
         $display("FAIL reset_outputs: rsp_valid=%b rsp_exc=%b rsp_data=%h, expected all 0",
                  rsp_valid, rsp_exc, rsp_data);
      end
      tests++;
      if (req_ready !== '0 || div_a !== 32'h0 || div_b !== 32'h0) begin
         fails++;
         $display("FAIL reset_bus: req_ready=%b div_a=%h div_b=%h, expected 0", req_ready, div_a, div_b);
      end
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
   endtask

   task automatic test_all_four();
      logic [31:0] expd [4];
      logic [3:0]  er, ev;
      set_op(0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
      set_op(1, 32'hBF800000, 32'h3F000000, 32'hC0000000, 1'b0);
      set_op(2, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
      set_op(3, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
      expd[0] = 32'h3F800000;
      expd[1] = 32'hC0000000;
      expd[2] = 32'h40400000;
      expd[3] = 32'h3F800000;
      req_valid = 4'hF;
      for (int c = 0; c < 8; c++) begin
         #1;
         er = (c < 4) ? 4'(1 << c) : 4'h0;
         ev = (c >= 3 && c < 7) ? 4'(1 << (c - 3)) : 4'h0;
         tests++;
         if (req_ready !== er) begin
            fails++;
            $display("FAIL all4_grant c%0d: req_ready=%b, expected %b", c, req_ready, er);
         end
         tests++;
         if (rsp_valid !== ev) begin
            fails++;
            $display("FAIL all4_rsp_valid c%0d: rsp_valid=%b, expected %b", c, rsp_valid, ev);
         end
         if (c >= 3 && c < 7) begin
            tests++;
            if (rsp_data[32*(c-3) +: 32] !== expd[c-3]) begin
               fails++;
               $display("FAIL all4_data c%0d: rsp_data%0d=%h, expected %h",
                        c, c - 3, rsp_data[32*(c-3) +: 32], expd[c-3]);
            end
         end
         cyc(1);
         if (c < 4) req_valid[c] = 1'b0;
      end
   endtask

   task automatic test_single();
      int lat;
      set_op(0, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
      req_valid = 4'b0001;
      #1;
      tests++;
      if (req_ready !== 4'b0001) begin
         fails++;
         $display("FAIL single_grant: req_ready=%b, expected 0001", req_ready);
      end
      tests++;
      if (div_a !== 32'h40C00000 || div_b !== 32'h40000000) begin
         fails++;
         $display("FAIL single_bus: div_a=%h div_b=%h, expected 40c00000 40000000", div_a, div_b);
      end
      cyc(1);
      req_valid = '0;
      wait_rsp(0, lat);
      tests++;
      if (lat + 1 !== 3) begin
         fails++;
         $display("FAIL single_latency: %0d cycles, expected 3", lat + 1);
      end
      tests++;
      if (rsp_data[31:0] !== 32'h40400000 || rsp_exc[0] !== 1'b0) begin
         fails++;
         $display("FAIL single_data: data=%h exc=%b, expected 40400000 0", rsp_data[31:0], rsp_exc[0]);
      end
      cyc(3);
   endtask

   task automatic test_backpressure();
      int          lat;
      int          others;
      logic [31:0] held;
      set_op(0, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
      set_op(1, 32'h3F800000, 32'h3F000000, 32'h40000000, 1'b0);
      set_op(2, 32'hBF800000, 32'h3F800000, 32'hBF800000, 1'b0);
      rsp_ready = 4'b1101;
      req_valid = 4'b0111;
      wait_rsp(1, lat);
      held = rsp_data[63:32];
      tests++;
      if (held !== 32'h40000000) begin
         fails++;
         $display("FAIL bp_data: rsp_data1=%h, expected 40000000", held);
      end
      others = 0;
      for (int c = 0; c < 15; c++) begin
         #1;
         if (c == 10) req_valid = 4'b0010;
         tests++;
         if (req_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b1 || rsp_data[63:32] !== held) begin
            fails++;
            $display("FAIL bp_hold c%0d: ready1=%b valid1=%b data1=%h, expected 0 1 %h",
                     c, req_ready[1], rsp_valid[1], rsp_data[63:32], held);
         end
         if (c < 10 && (req_ready[0] || req_ready[2])) others++;
         cyc(1);
      end
      tests++;
      if (others < 6) begin
         fails++;
         $display("FAIL bp_rotation: %0d grants to others in 10 cycles, expected >= 6", others);
      end
      rsp_ready = 4'b1111;
      #1;
      tests++;
      if (req_ready !== 4'b0010) begin
         fails++;
         $display("FAIL bp_reissue: req_ready=%b, expected 0010", req_ready);
      end
      cyc(1);
      req_valid = '0;
      wait_rsp(1, lat);
      cyc(3);
   endtask

   task automatic test_special();
      int          lat;
      logic [31:0] bs [2];
      bs[0] = 32'h00000000;
      bs[1] = 32'h7F800000;
      for (int k = 0; k < 2; k++) begin
         set_op(2 + k, 32'h3F800000, bs[k], 32'h7FC00000, 1'b1);
         req_valid = 4'(1 << (2 + k));
         #1;
         tests++;
         if (req_ready !== 4'(1 << (2 + k))) begin
            fails++;
            $display("FAIL special_grant%0d: req_ready=%b, expected %b", k, req_ready, 4'(1 << (2 + k)));
         end
         cyc(1);
         req_valid = '0;
         wait_rsp(2 + k, lat);
         tests++;
         if (rsp_exc[2 + k] !== 1'b1) begin
            fails++;
            $display("FAIL special_exc%0d: rsp_exc=%b, expected bit %0d set", k, rsp_exc, 2 + k);
         end
         cyc(3);
      end
   endtask

   task automatic test_reset_mid();
      set_op(0, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
      set_op(2, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
      req_valid = 4'b0101;
      #1;
      tests++;
      if (req_ready !== 4'b0001) begin
         fails++;
         $display("FAIL rstmid_grant0: req_ready=%b, expected 0001", req_ready);
      end
      cyc(1);
      tests++;
      if (req_ready !== 4'b0100) begin
         fails++;
         $display("FAIL rstmid_grant2: req_ready=%b, expected 0100", req_ready);
      end
      cyc(1);
      req_valid = '0;
      rst_n     = 1'b0;
      #1;
      for (int i = 0; i < int'(NR); i++) sbq[i].delete();
      tests++;
      if (rsp_valid !== '0 || rsp_data !== '0 || rsp_exc !== '0) begin
         fails++;
         $display("FAIL rstmid_clear: rsp_valid=%b rsp_data=%h rsp_exc=%b, expected 0",
                  rsp_valid, rsp_data, rsp_exc);
      end
      cyc(1);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         cyc(1);
         tests++;
         if (rsp_valid !== '0) begin
            fails++;
            $display("FAIL rstmid_ghost c%0d: rsp_valid=%b, expected 0000", c, rsp_valid);
         end
      end
   endtask

   task automatic test_fairness();
      set_op(0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
      set_op(3, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
      gnt_log.delete();
      rsp_ready = 4'b1111;
      req_valid = 4'b1001;
      cyc(12);
      req_valid = '0;
      tests++;
      if (gnt_log.size() !== 8) begin
         fails++;
         $display("FAIL fair_count: %0d grants in 12 cycles, expected 8", gnt_log.size());
      end
      for (int k = 0; k < gnt_log.size() && k < 8; k++) begin
         tests++;
         if (gnt_log[k] !== ((k % 2 == 0) ? 0 : 3)) begin
            fails++;
            $display("FAIL fair_order k%0d: granted %0d, expected %0d", k, gnt_log[k], (k % 2 == 0) ? 0 : 3);
         end
      end
      cyc(6);
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = '1;
      for (int i = 0; i < int'(NR); i++) exp_in[i] = '0;

      test_reset();
      test_all_four();
      test_single();
      test_backpressure();
      test_special();
      test_reset_mid();
      test_fairness();

      for (int i = 0; i < int'(NR); i++) begin
         tests++;
         if (sbq[i].size() != 0) begin
            fails++;
            $display("FAIL drain req%0d: %0d results never returned, expected 0", i, sbq[i].size());
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
